// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the PC, drives it to IMEM and
//               captures the returned word into the IF/ID register. Handles
//               sequential advance, stall, and branch redirect with flush.
//               Optional macro FETCH_PERF_EN adds a saturating 16-bit
//               fetch counter on port fetch_count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic [31:0] theInstruction,
    output logic [31:0] PC_Out,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PC,
`ifdef FETCH_PERF_EN
    output logic        IF_Valid,
    output logic [15:0] fetch_count
`else
    output logic        IF_Valid
`endif
);

    localparam logic [15:0] c_count_max = 16'hFFFF;

    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    // A fetch is accepted into IF/ID only when neither redirected nor held.
    logic        w_load;
    assign w_load = !branch_valid && !stall;

    // Program counter: reset, then redirect, then hold, then sequential step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (branch_valid) begin
            r_pc <= branch_target;
        end else if (!stall) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // IF/ID register: a branch flushes the wrong-path word fetched this cycle.
    always_ff @(posedge clk) begin
        if (reset || branch_valid) begin
            r_if_instr <= 32'd0;
            r_if_pc    <= 32'd0;
            r_if_valid <= 1'b0;
        end else if (w_load) begin
            r_if_instr <= theInstruction;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
        end
    end

    assign PC_Out   = r_pc;
    assign IF_Instr = r_if_instr;
    assign IF_PC    = r_if_pc;
    assign IF_Valid = r_if_valid;

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_count;

    // Count valid IF/ID loads, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 16'd0;
        end else if (w_load && (r_fetch_count != c_count_max)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Two instances (reset PC
//               0 and 6) share stimulus; each is compared every cycle against
//               a transaction-level model, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_special = 32'hE081_0312;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'd0;

    logic [31:0] pc_a, instr_a, ifi_a, ifpc_a;
    logic [31:0] pc_b, instr_b, ifi_b, ifpc_b;
    logic        ifv_a, ifv_b;
`ifdef FETCH_PERF_EN
    logic [15:0] fc_a, fc_b;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state, one slot per instance.
    logic [31:0] m_rst  [2] = '{32'd0, 32'd6};
    logic [31:0] m_pc   [2];
    logic [31:0] m_ifi  [2];
    logic [31:0] m_ifpc [2];
    logic        m_ifv  [2];
    int          m_cnt  [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [3:0] a);
        return (a == 4'd7) ? c_special : {28'd0, a};
    endfunction

    assign instr_a = imem(pc_a[3:0]);
    assign instr_b = imem(pc_b[3:0]);

    fetch_stage #(.RESET_PC(32'd0), .PC_STEP(32'd1)) u_a (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .theInstruction(instr_a), .PC_Out(pc_a), .IF_Instr(ifi_a),
`ifdef FETCH_PERF_EN
        .IF_PC(ifpc_a), .IF_Valid(ifv_a), .fetch_count(fc_a)
`else
        .IF_PC(ifpc_a), .IF_Valid(ifv_a)
`endif
    );

    fetch_stage #(.RESET_PC(32'd6), .PC_STEP(32'd1)) u_b (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .theInstruction(instr_b), .PC_Out(pc_b), .IF_Instr(ifi_b),
`ifdef FETCH_PERF_EN
        .IF_PC(ifpc_b), .IF_Valid(ifv_b), .fetch_count(fc_b)
`else
        .IF_PC(ifpc_b), .IF_Valid(ifv_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge as the fetch rules describe it, applied to both models.
    task automatic model_edge(input logic rs, input logic br, input logic st, input logic [31:0] tg);
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                m_pc[k] = m_rst[k]; m_ifi[k] = 0; m_ifpc[k] = 0; m_ifv[k] = 0; m_cnt[k] = 0;
            end else if (br) begin
                m_pc[k] = tg; m_ifi[k] = 0; m_ifpc[k] = 0; m_ifv[k] = 0;
            end else if (!st) begin
                m_ifi[k]  = imem(m_pc[k][3:0]);
                m_ifpc[k] = m_pc[k];
                m_ifv[k]  = 1'b1;
                m_pc[k]   = m_pc[k] + 32'd1;
                m_cnt[k]  = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
            end
        end
    endtask

    task automatic compare_all();
        check("pc_a",   pc_a,   m_pc[0]);
        check("ifi_a",  ifi_a,  m_ifi[0]);
        check("ifpc_a", ifpc_a, m_ifpc[0]);
        check("ifv_a",  {31'd0, ifv_a}, {31'd0, m_ifv[0]});
        check("pc_b",   pc_b,   m_pc[1]);
        check("ifi_b",  ifi_b,  m_ifi[1]);
        check("ifpc_b", ifpc_b, m_ifpc[1]);
        check("ifv_b",  {31'd0, ifv_b}, {31'd0, m_ifv[1]});
`ifdef FETCH_PERF_EN
        check("cnt_a",  {16'd0, fc_a}, m_cnt[0]);
        check("cnt_b",  {16'd0, fc_b}, m_cnt[1]);
`endif
    endtask

    // Drive inputs, take one edge, sample 1 ns later and compare to the model.
    task automatic step(input logic rs, input logic br, input logic st, input logic [31:0] tg);
        reset = rs; branch_valid = br; stall = st; branch_target = tg;
        @(posedge clk);
        #1;
        model_edge(rs, br, st, tg);
        compare_all();
    endtask

    initial begin
        // Reset state.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_pc_a",  pc_a, 32'd0);
        check("rst_pc_b",  pc_b, 32'd6);
        check("rst_ifv_a", {31'd0, ifv_a}, 32'd0);
        check("rst_ifi_a", ifi_a, 32'd0);

        // Sequential fetch: A walks 0..4, B fetches the special word at 7.
        step(0, 0, 0, 0);
        check("seq1_ifv_a",  {31'd0, ifv_a}, 32'd1);
        check("seq1_ifpc_a", ifpc_a, 32'd0);
        check("seq1_pc_b",   pc_b, 32'd7);
        step(0, 0, 0, 0);
        check("seq2_ifi_b",  ifi_b, c_special);
        check("seq2_ifpc_b", ifpc_b, 32'd7);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("seq4_pc_a",   pc_a, 32'd4);
        check("seq4_ifi_a",  ifi_a, 32'd3);

        // Stall three cycles at PC=3, then resume without skip or duplicate.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            check("stall_pc_a",   pc_a, 32'd3);
            check("stall_ifpc_a", ifpc_a, 32'd2);
            check("stall_ifv_a",  {31'd0, ifv_a}, 32'd1);
        end
        step(0, 0, 0, 0);
        check("resume_ifpc_a", ifpc_a, 32'd3);
        check("resume_pc_a",   pc_a, 32'd4);

        // Branch together with stall at PC=2: branch wins, one bubble.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'd7);
        check("br_pc_a",  pc_a, 32'd7);
        check("br_ifv_a", {31'd0, ifv_a}, 32'd0);
        step(0, 0, 0, 0);
        check("br_ifi_a", ifi_a, c_special);
        check("br_ifv2_a", {31'd0, ifv_a}, 32'd1);

        // PC wrap at 2^32.
        step(0, 1, 0, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        check("wrap_pc_a",   pc_a, 32'd0);
        check("wrap_ifpc_a", ifpc_a, 32'hFFFF_FFFF);

        // Reset mid-stall.
        step(0, 0, 1, 0);
        step(1, 1, 1, 32'h1234_5678);
        check("rst_mid_pc_a",  pc_a, 32'd0);
        check("rst_mid_ifv_a", {31'd0, ifv_a}, 32'd0);
        check("rst_mid_ifpc_a", ifpc_a, 32'd0);

`ifdef FETCH_PERF_EN
        // Counter saturation from a preloaded value.
        force u_a.r_fetch_count = 16'hFFFE;
        force u_b.r_fetch_count = 16'hFFFE;
        #1;
        release u_a.r_fetch_count;
        release u_b.r_fetch_count;
        m_cnt[0] = 16'hFFFE;
        m_cnt[1] = 16'hFFFE;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 32'd3);
        check("sat_cnt_a", {16'd0, fc_a}, 32'h0000_FFFF);
        step(1, 0, 0, 0);
        check("sat_clr_a", {16'd0, fc_a}, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic rs, br, st;
            logic [31:0] tg;
            rs = ($urandom_range(99) < 2);
            br = ($urandom_range(99) < 15);
            st = ($urandom_range(99) < 25);
            tg = ($urandom_range(1) == 0) ? $urandom : {28'd0, 4'($urandom)};
            step(rs, br, st, tg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
